// File: rtl/cdc_pkg.sv
// Shared types and legality limits for the CDC sequencer chain.
// Holds the transmit FSM state encoding and minimum parameter values.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } cdc_tx_state_t;

    localparam int MIN_SETUP_CYCLES = 1;
    localparam int MIN_SYNC_DEPTH   = 2;

endpackage

// File: rtl/cdc_bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level/toggle.
// Ports: clk, sync_rst (sync, active-high), d (async in), q (synced out).
module cdc_bit_synchronizer
    import cdc_pkg::*;
#(
    parameter int   DEPTH       = 3,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic d,
    output logic q
);

    if (DEPTH < MIN_SYNC_DEPTH) begin : gDepthCheck
        $error("cdc_bit_synchronizer: DEPTH below minimum");
    end

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            stages <= {DEPTH{RESET_VALUE}};
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/cdc_sequencer_transmitter.sv
// Source-domain side of a bundled-data crossing: TxData is held stable
// for SETUP_CYCLES, then TxToggle flips and the word is held until the
// synchronised AckToggle equals TxToggle.
// Ports: clk, sync_rst; InputValid/InputReady/InputData producer handshake;
// TxData/TxToggle crossing bus; AckToggle far-side ack; Busy; TxCount.
module cdc_sequencer_transmitter
    import cdc_pkg::*;
#(
    parameter int DATA_BITWIDTH  = 5,
    parameter int SETUP_CYCLES   = 2,
    parameter int ACK_SYNC_DEPTH = 3,
    parameter int COUNT_BITWIDTH = 16
) (
    input  logic                      clk,
    input  logic                      sync_rst,
    input  logic                      InputValid,
    output logic                      InputReady,
    input  logic [DATA_BITWIDTH-1:0]  InputData,
    output logic [DATA_BITWIDTH-1:0]  TxData,
    output logic                      TxToggle,
    input  logic                      AckToggle,
    output logic                      Busy,
    output logic [COUNT_BITWIDTH-1:0] TxCount
);

    if (SETUP_CYCLES < MIN_SETUP_CYCLES) begin : gSetupCheck
        $error("cdc_sequencer_transmitter: SETUP_CYCLES below minimum");
    end

    localparam int CNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETUP_CYCLES - 1);

    cdc_tx_state_t              state, stateNext;
    logic [CNT_W-1:0]           setupCnt, setupCntNext;
    logic [DATA_BITWIDTH-1:0]   dataNext;
    logic                       toggleNext;
    logic [COUNT_BITWIDTH-1:0]  countNext;
    logic                       ackSynced;

    cdc_bit_synchronizer #(
        .DEPTH       (ACK_SYNC_DEPTH),
        .RESET_VALUE (1'b0)
    ) uAckSync (
        .clk      (clk),
        .sync_rst (sync_rst),
        .d        (AckToggle),
        .q        (ackSynced)
    );

    assign InputReady = (state == IDLE) & ~sync_rst;
    assign Busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state    <= IDLE;
            setupCnt <= '0;
            TxData   <= '0;
            TxToggle <= 1'b0;
            TxCount  <= '0;
        end else begin
            state    <= stateNext;
            setupCnt <= setupCntNext;
            TxData   <= dataNext;
            TxToggle <= toggleNext;
            TxCount  <= countNext;
        end
    end

    always_comb begin
        stateNext    = state;
        setupCntNext = setupCnt;
        dataNext     = TxData;
        toggleNext   = TxToggle;
        countNext    = TxCount;
        unique case (state)
            IDLE: begin
                if (InputValid) begin
                    dataNext     = InputData;
                    setupCntNext = CNT_LOAD;
                    stateNext    = SETUP;
                end
            end
            SETUP: begin
                if (setupCnt != '0) begin
                    setupCntNext = setupCnt - 1'b1;
                end else begin
                    toggleNext = ~TxToggle;
                    stateNext  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // Level compare: a stale ack cannot match the freshly
                // flipped toggle.
                if (ackSynced == TxToggle) begin
                    countNext = TxCount + COUNT_BITWIDTH'(1);
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cdc_sequencer_transmitter.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// each cycle against a timestamp-based transaction model.
module tb_cdc_sequencer_transmitter;

    localparam int DW = 5;
    localparam int S  = 2;
    localparam int D  = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ack;
    logic [DW-1:0] inData;

    logic          ready,  ready2;
    logic [DW-1:0] txData, txData2;
    logic          txTog,  txTog2;
    logic          busy,   busy2;
    logic [CW-1:0] txCnt;
    logic [1:0]    txCnt2;

    cdc_sequencer_transmitter #(
        .DATA_BITWIDTH(DW), .SETUP_CYCLES(S),
        .ACK_SYNC_DEPTH(D), .COUNT_BITWIDTH(CW)
    ) dut (
        .clk(clk), .sync_rst(rst),
        .InputValid(valid), .InputReady(ready), .InputData(inData),
        .TxData(txData), .TxToggle(txTog), .AckToggle(ack),
        .Busy(busy), .TxCount(txCnt)
    );

    cdc_sequencer_transmitter #(
        .DATA_BITWIDTH(DW), .SETUP_CYCLES(S),
        .ACK_SYNC_DEPTH(D), .COUNT_BITWIDTH(2)
    ) dut2 (
        .clk(clk), .sync_rst(rst),
        .InputValid(valid), .InputReady(ready2), .InputData(inData),
        .TxData(txData2), .TxToggle(txTog2), .AckToggle(ack),
        .Busy(busy2), .TxCount(txCnt2)
    );

    initial forever #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int edgeN      = 0;

    // Transaction model: a word is "in flight" from its accept edge;
    // the toggle flips S edges later; completion is the first later
    // edge where the ack value from D edges ago equals the toggle.
    bit            mBusy   = 0;
    bit            mToggle = 0;
    logic [DW-1:0] mData   = '0;
    int unsigned   mCount  = 0;
    int            mAcc    = 0;
    int            lastRst = -1;
    bit            loop    = 0;
    bit            accNow  = 0;
    bit            ackHist [0:4095];

    function automatic bit syncedAck(int n);
        if (n - D > lastRst && n - D >= 0) return ackHist[(n - D) % 4096];
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ackHist[edgeN % 4096] = ack;
        accNow = 0;
        if (rst) begin
            mBusy = 0; mToggle = 0; mData = '0; mCount = 0;
            lastRst = edgeN;
        end else if (!mBusy) begin
            if (valid) begin
                mBusy = 1; mData = inData; mAcc = edgeN; accNow = 1;
            end
        end else if (edgeN - mAcc == S) begin
            mToggle = ~mToggle;
        end else if (edgeN - mAcc > S && syncedAck(edgeN) == mToggle) begin
            mBusy = 0;
            mCount++;
        end
        #1;
        chk("TxData",     32'(txData), 32'(mData));
        chk("TxToggle",   32'(txTog),  32'(mToggle));
        chk("Busy",       32'(busy),   32'(mBusy));
        chk("InputReady", 32'(ready),  32'(!mBusy && !rst));
        chk("TxCount",    32'(txCnt),  mCount & 32'hFFFF);
        chk("TxCount2b",  32'(txCnt2), mCount & 32'h3);
        if (loop) ack = mToggle;
        edgeN++;
    endtask

    initial begin
        logic [DW-1:0] words [0:2];
        int            k;
        rst = 1; valid = 0; ack = 0; inData = '0;

        // Reset state
        repeat (3) tick();
        rst = 0;

        // Single word 0x15 in loopback
        loop = 1;
        valid = 1; inData = 5'h15;
        tick();
        chk("accept_0x15", 32'(accNow), 32'd1);
        valid = 0; inData = DW'($urandom);
        repeat (8) tick();
        chk("count_after_0x15", 32'(txCnt), 32'd1);

        // Back-to-back with valid held high
        words[0] = 5'h01; words[1] = 5'h1F; words[2] = 5'h0A;
        k = 0;
        valid = 1; inData = words[0];
        for (int i = 0; i < 40 && k < 3; i++) begin
            tick();
            if (accNow) begin
                k++;
                if (k < 3) inData = words[k];
                else valid = 0;
            end
        end
        chk("b2b_accepts", 32'(k), 32'd3);
        repeat (8) tick();
        chk("count_after_b2b", 32'(txCnt), 32'd4);

        // Stalled ack from a fresh reset
        loop = 0; ack = 0; rst = 1;
        repeat (2) tick();
        rst = 0;
        valid = 1; inData = 5'h07;
        tick();
        valid = 0;
        repeat (50) tick();
        chk("stall_busy", 32'(busy), 32'd1);
        ack = 1;
        repeat (D + 3) tick();
        chk("stall_release", 32'(busy), 32'd0);

        // Ack glitch while in SETUP
        rst = 1; ack = 0;
        tick();
        rst = 0;
        valid = 1; inData = DW'($urandom);
        tick();
        valid = 0; ack = 1;
        tick();
        ack = 0;
        repeat (12) tick();
        ack = 1;
        repeat (8) tick();

        // Reset during WAIT_ACK, then resume with 0x03
        ack = 0; rst = 1;
        tick();
        rst = 0;
        valid = 1; inData = 5'h1C;
        tick();
        valid = 0;
        repeat (6) tick();
        rst = 1;
        repeat (2) tick();
        rst = 0; loop = 1;
        valid = 1; inData = 5'h03;
        tick();
        valid = 0;
        repeat (9) tick();
        chk("count_after_rst", 32'(txCnt), 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) loop = ($urandom_range(0, 2) != 0);
            valid  = ($urandom_range(0, 2) != 0);
            inData = DW'($urandom);
            rst    = ($urandom_range(0, 149) == 0);
            if (!loop && $urandom_range(0, 3) == 0) ack = ~ack;
            tick();
        end
        rst = 0; valid = 0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
